conv_patch_streamer: RTL and testbench

Converts a raster-scan stream of multi-channel pixels into packed K×K×CHANNELS patch words for the `conv` tile engine. For every valid convolution position of an IMG_WIDTH×IMG_HEIGHT frame it emits exactly one patch. Each patch is bit-compatible with `conv.inpData` and is handed downstream over a valid/ready handshake. It sits between the pixel source (camera/DMA) and `conv`, and replaces file-driven patch feeding.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_patch_streamer_if.sv | 33 +++
 rtl/patch_line_buffer.sv | 23 ++
 rtl/conv_patch_streamer.sv | 134 +++++++++++++
 tb/tb_conv_patch_streamer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv patch path: default geometry, patch width,
// FSM state encoding and the patch bit-offset helper.
package conv_pkg;

  localparam int DEF_KERNEL_SIZE      = 3;
  localparam int DEF_INPUT_DATA_WIDTH = 8;
  localparam int DEF_CHANNELS         = 3;
  localparam int PATCH_BITS = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE * DEF_INPUT_DATA_WIDTH * DEF_CHANNELS;

  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  // Channel-major packing; within a channel element 0 (top-left) lands in the MSBs.
  function automatic int patch_off(input int ch, input int e, input int w, input int ne);
    return ch * ne * w + (ne - 1 - e) * w;
  endfunction

endpackage

// File: rtl/conv_patch_streamer_if.sv
// Pixel-in / patch-out handshake bundle for conv_patch_streamer.
// PATCH_COORD_EN adds the patch_row/patch_col coordinate signals.
interface conv_patch_streamer_if #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CHANNELS         = 3,
  parameter int KERNEL_SIZE      = 3
);
  localparam int PIX_BITS = CHANNELS * INPUT_DATA_WIDTH;
  localparam int PATCH_W  = KERNEL_SIZE * KERNEL_SIZE * PIX_BITS;

  logic                pix_valid;
  logic                pix_ready;
  logic [PIX_BITS-1:0] pix_data;
  logic                patch_valid;
  logic                patch_ready;
  logic [PATCH_W-1:0]  patch_data;
  logic                frame_done;
`ifdef PATCH_COORD_EN
  logic [15:0]         patch_row;
  logic [15:0]         patch_col;

  modport master (output pix_valid, pix_data, patch_ready,
                  input  pix_ready, patch_valid, patch_data, frame_done, patch_row, patch_col);
  modport slave  (input  pix_valid, pix_data, patch_ready,
                  output pix_ready, patch_valid, patch_data, frame_done, patch_row, patch_col);
`else
  modport master (output pix_valid, pix_data, patch_ready,
                  input  pix_ready, patch_valid, patch_data, frame_done);
  modport slave  (input  pix_valid, pix_data, patch_ready,
                  output pix_ready, patch_valid, patch_data, frame_done);
`endif

endinterface

// File: rtl/patch_line_buffer.sv
// One image row of pixels: combinational read, synchronous write, no reset
// (every entry is rewritten before the window consumes it).
module patch_line_buffer #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_patch_streamer.sv
// Raster pixel stream -> packed 3x3xC patch words for the conv tile engine.
// Define PATCH_COORD_EN to add the patch_row/patch_col window-origin outputs.
module conv_patch_streamer import conv_pkg::*; #(
  parameter int KERNEL_SIZE      = DEF_KERNEL_SIZE,
  parameter int INPUT_DATA_WIDTH = DEF_INPUT_DATA_WIDTH,
  parameter int CHANNELS         = DEF_CHANNELS,
  parameter int IMG_WIDTH        = 512,
  parameter int IMG_HEIGHT       = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  conv_patch_streamer_if.slave  bus
);

  localparam int W  = INPUT_DATA_WIDTH;
  localparam int PW = CHANNELS * W;
  localparam int K  = KERNEL_SIZE;
  localparam int NE = K * K;
  localparam int PB = NE * PW;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col, ncol;
  logic [RW-1:0] row, nrow;
  state_t        state, nstate;
  logic          accept, emit, last_pix;
  logic          pvld, fdone;
  logic [PB-1:0] pdata, npatch;
  logic [PW-1:0] win  [K][K];
  logic [PW-1:0] nwin [K][K];
  logic [PW-1:0] lb_rd [2];
  logic [PW-1:0] lb_wd [2];

  assign bus.pix_ready   = !pvld || bus.patch_ready;
  assign bus.patch_valid = pvld;
  assign bus.patch_data  = pdata;
  assign bus.frame_done  = fdone;
  assign accept          = bus.pix_valid && bus.pix_ready;

  // lb[0] holds row-1, lb[1] holds row-2; lb[1] is fed by lb[0]'s old entry.
  assign lb_wd[0] = bus.pix_data;
  assign lb_wd[1] = lb_rd[0];

  for (genvar i = 0; i < 2; i++) begin : g_lb
    patch_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb_wd[i]),
      .rdata (lb_rd[i])
    );
  end

  for (genvar r = 0; r < K; r++) begin : g_shift
    for (genvar c = 0; c < K - 1; c++) begin : g_col
      assign nwin[r][c] = win[r][c+1];
    end
  end
  assign nwin[0][K-1] = lb_rd[1];
  assign nwin[1][K-1] = lb_rd[0];
  assign nwin[2][K-1] = bus.pix_data;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    for (genvar e = 0; e < NE; e++) begin : g_el
      assign npatch[patch_off(ch, e, W, NE) +: W] = nwin[e / K][e % K][ch*W +: W];
    end
  end

  assign last_pix = (row == RW'(IMG_HEIGHT - 1)) && (col == CW'(IMG_WIDTH - 1));

  always_comb begin
    ncol   = col + CW'(1);
    nrow   = row;
    nstate = state;
    emit   = 1'b0;
    if (col == CW'(IMG_WIDTH - 1)) begin
      ncol = '0;
      nrow = (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
    end
    if (accept) begin
      emit   = (state == EMIT);
      nstate = (nrow >= RW'(2) && ncol >= CW'(2)) ? EMIT : FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (accept) win <= nwin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col   <= '0;
      row   <= '0;
      pvld  <= 1'b0;
      pdata <= '0;
      fdone <= 1'b0;
    end else begin
      fdone <= 1'b0;
      if (accept) begin
        col <= ncol;
        row <= nrow;
      end
      if (emit) begin
        pvld  <= 1'b1;
        pdata <= npatch;
        fdone <= last_pix;
      end else if (bus.patch_ready) begin
        pvld <= 1'b0;
      end
    end
  end

`ifdef PATCH_COORD_EN
  logic [15:0] prow, pcol;
  assign bus.patch_row = prow;
  assign bus.patch_col = pcol;

  always_ff @(posedge clk) begin
    if (reset) begin
      prow <= '0;
      pcol <= '0;
    end else if (emit) begin
      prow <= 16'(row) - 16'd2;
      pcol <= 16'(col) - 16'd2;
    end
  end
`endif

endmodule

// File: tb/tb_conv_patch_streamer.sv
// Scoreboarded bench for conv_patch_streamer on a 4x4 frame; checks coordinates
// too when PATCH_COORD_EN is defined.
module tb_conv_patch_streamer;

  localparam int W  = 8;
  localparam int C  = 3;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int PB = 9 * W * C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  conv_patch_streamer_if #(.INPUT_DATA_WIDTH(W), .CHANNELS(C), .KERNEL_SIZE(3)) bus ();

  conv_patch_streamer #(
    .KERNEL_SIZE(3), .INPUT_DATA_WIDTH(W), .CHANNELS(C),
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [PB-1:0] data;
    bit            last;
    int            r;
    int            c;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0, fails = 0;
  int pushes = 0, pops = 0, exp_fd = 0, fdones = 0;

  function automatic logic [23:0] mkpix(int mode, int f, int r, int c);
    int b;
    if (mode == 1) return 24'hFFFFFF;
    b = r * 4 + c + f * 64;
    return {8'(b + 32), 8'(b + 16), 8'(b)};
  endfunction

  function automatic logic [PB-1:0] mkpatch(int mode, int f, int r0, int c0);
    logic [PB-1:0] p;
    logic [23:0]   px;
    p = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int e = 0; e < 9; e++) begin
        px = mkpix(mode, f, r0 + e / 3, c0 + e % 3);
        p[ch*72 + (8-e)*8 +: 8] = px[ch*8 +: 8];
      end
    return p;
  endfunction

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && bus.frame_done) begin
      fdones++;
      tests++;
      assert (bus.patch_valid === 1'b1 && exp_q.size() > 0 && exp_q[0].last)
      else begin
        fails++;
        $error("FAIL frame_done_align: valid=%0b qsize=%0d, required valid=1 on last patch",
               bus.patch_valid, exp_q.size());
      end
    end
    if (!reset && bus.patch_valid === 1'b1 && bus.patch_ready === 1'b1) begin
      tests++;
      assert (exp_q.size() > 0)
      else begin
        fails++;
        $error("FAIL unexpected_patch: got %h, required no patch", bus.patch_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pops++;
        tests++;
        assert (bus.patch_data === e.data)
        else begin
          fails++;
          $error("FAIL patch_data(%0d,%0d): got %h required %h", e.r, e.c, bus.patch_data, e.data);
        end
`ifdef PATCH_COORD_EN
        tests++;
        assert (bus.patch_row === 16'(e.r) && bus.patch_col === 16'(e.c))
        else begin
          fails++;
          $error("FAIL patch_coord: got (%0d,%0d) required (%0d,%0d)",
                 bus.patch_row, bus.patch_col, e.r, e.c);
        end
`endif
      end
    end
  end

  task automatic send_pixel(input logic [23:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    @(negedge clk);
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    while (!acc && n < 50) begin
      if (n > 0) @(negedge clk);
      #1 acc = bus.pix_ready;
      @(posedge clk);
      n++;
    end
    if (!acc) begin
      tests++;
      assert (acc) else begin
        fails++;
        $error("FAIL pix_accept_timeout: accepted=%0b required 1", acc);
      end
    end
  endtask

  task automatic do_stall(input logic [23:0] nd);
    @(negedge clk);
    bus.patch_ready = 1'b0;
    bus.pix_valid   = 1'b1;
    bus.pix_data    = nd;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      assert (bus.pix_ready === 1'b0) else begin
        fails++;
        $error("FAIL stall_pix_ready: got %0b required 0", bus.pix_ready);
      end
      tests++;
      assert (bus.patch_valid === 1'b1 && bus.patch_data === exp_q[0].data) else begin
        fails++;
        $error("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h",
               bus.patch_valid, bus.patch_data, exp_q[0].data);
      end
      @(negedge clk);
    end
    bus.patch_ready = 1'b1;
    bus.pix_valid   = 1'b0;
  endtask

  task automatic send_frame(input int mode, input int f, input bit gaps, input bit stall, input int npix);
    exp_t e;
    int r, c;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / IW;
      c = idx % IW;
      if (gaps && (idx % 2) == 1) begin
        @(negedge clk);
        bus.pix_valid = 1'b0;
      end
      if (r >= 2 && c >= 2) begin
        e.data = mkpatch(mode, f, r - 2, c - 2);
        e.last = (r == IH - 1) && (c == IW - 1);
        e.r = r - 2;
        e.c = c - 2;
        exp_q.push_back(e);
        pushes++;
        if (e.last) exp_fd++;
      end
      send_pixel(mkpix(mode, f, r, c));
      if (stall && r == 2 && c == 2) do_stall(mkpix(mode, f, (idx + 1) / IW, (idx + 1) % IW));
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    tests++;
    assert (exp_q.size() == 0 && pops == pushes) else begin
      fails++;
      $error("FAIL %s_count: popped=%0d left=%0d required popped=%0d left=0", tag, pops, exp_q.size(), pushes);
    end
    tests++;
    assert (fdones == exp_fd) else begin
      fails++;
      $error("FAIL %s_frame_done: got %0d pulses required %0d", tag, fdones, exp_fd);
    end
    tests++;
    assert (bus.patch_valid === 1'b0) else begin
      fails++;
      $error("FAIL %s_drain: patch_valid=%0b required 0", tag, bus.patch_valid);
    end
  endtask

  initial begin
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.patch_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    assert (bus.patch_valid === 1'b0 && bus.frame_done === 1'b0) else begin
      fails++;
      $error("FAIL reset_valid: valid=%0b done=%0b required 0/0", bus.patch_valid, bus.frame_done);
    end
    tests++;
    assert (bus.patch_data === '0) else begin
      fails++;
      $error("FAIL reset_data: got %h required 0", bus.patch_data);
    end
    tests++;
    assert (bus.pix_ready === 1'b1) else begin
      fails++;
      $error("FAIL reset_pix_ready: got %0b required 1", bus.pix_ready);
    end

    send_frame(0, 0, 1'b0, 1'b0, IW * IH);
    idle_check(4, "basic");

    send_frame(0, 1, 1'b0, 1'b1, IW * IH);
    idle_check(4, "stall");

    send_frame(0, 2, 1'b0, 1'b0, IW * IH);
    send_frame(0, 3, 1'b0, 1'b0, IW * IH);
    idle_check(4, "b2b");

    // abort after pixel (2,1), then a clean frame
    send_frame(0, 1, 1'b0, 1'b0, 2 * IW + 2);
    @(negedge clk);
    reset = 1'b1;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    assert (bus.patch_valid === 1'b0 && bus.pix_ready === 1'b1) else begin
      fails++;
      $error("FAIL midreset: valid=%0b ready=%0b required 0/1", bus.patch_valid, bus.pix_ready);
    end
    send_frame(0, 2, 1'b0, 1'b0, IW * IH);
    idle_check(4, "after_reset");

    send_frame(1, 0, 1'b0, 1'b0, IW * IH);
    idle_check(4, "all_ones");

    send_frame(0, 0, 1'b1, 1'b0, IW * IH);
    idle_check(4, "gaps");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
